lift_scheduler: RTL and testbench

LIFT_SCHEDULER -- requirements
Module: lift_scheduler

---
 rtl/lift_pkg.sv | 24 ++
 rtl/lift_car.sv | 125 ++++++++++++
 rtl/lift_scheduler.sv | 135 +++++++++++++
 tb/tb_lift_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared types and encodings for the two-car lift scheduler.
// Holds the car FSM state type, floor width and dispatch encodings.
package lift_pkg;

    localparam int FLOOR_W = 3;

    typedef logic [FLOOR_W-1:0] floor_t;
    typedef logic [1:0]         lift_state_t;
    typedef logic [1:0]         assign_t;

    localparam lift_state_t ST_IDLE      = 2'd0;
    localparam lift_state_t ST_MOVE_UP   = 2'd1;
    localparam lift_state_t ST_MOVE_DOWN = 2'd2;
    localparam lift_state_t ST_DOOR      = 2'd3;

    localparam assign_t ASSIGN_NONE = 2'b00;
    localparam assign_t ASSIGN_L1   = 2'b01;
    localparam assign_t ASSIGN_L2   = 2'b10;

    function automatic floor_t floor_dist(input floor_t a, input floor_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/lift_car.sv
// One lift car: FSM plus step and door down-counters.
//   state        | meaning
//   ST_IDLE      | parked, doors closed, accepts a new target
//   ST_MOVE_UP   | travelling toward a higher target floor
//   ST_MOVE_DOWN | travelling toward a lower target floor
//   ST_DOOR      | doors open at the target for DOOR_CYCLES cycles
module lift_car
    import lift_pkg::*;
#(
    parameter int     MOVE_CYCLES = 2,
    parameter int     DOOR_CYCLES = 4,
    parameter floor_t HOME        = 3'd0
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_start,
    input  floor_t i_target,
    output logic   o_idle,
    output floor_t o_floor,
    output logic   o_im,
    output logic   o_up,
    output logic   o_door,
    output logic   o_arrive,
    output floor_t o_arrive_floor
);

    localparam int TW = 16;
    localparam logic [TW-1:0] STEP_RELOAD = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_RELOAD = TW'(DOOR_CYCLES - 1);

    lift_state_t   r_state;
    floor_t        r_floor;
    floor_t        r_target;
    logic [TW-1:0] r_step_cnt;
    logic [TW-1:0] r_door_cnt;

    lift_state_t   w_state_nxt;
    floor_t        w_floor_nxt;
    floor_t        w_target_nxt;
    logic [TW-1:0] w_step_nxt;
    logic [TW-1:0] w_door_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_target_nxt = r_target;
        w_step_nxt   = r_step_cnt;
        w_door_nxt   = r_door_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_target_nxt = i_target;
                    if (i_target > r_floor) begin
                        w_state_nxt = ST_MOVE_UP;
                        w_step_nxt  = STEP_RELOAD;
                    end else if (i_target < r_floor) begin
                        w_state_nxt = ST_MOVE_DOWN;
                        w_step_nxt  = STEP_RELOAD;
                    end else begin
                        w_state_nxt = ST_DOOR;
                        w_door_nxt  = DOOR_RELOAD;
                    end
                end
            end
            ST_MOVE_UP: begin
                if (r_step_cnt == '0) begin
                    w_floor_nxt = (r_floor == '1) ? r_floor : r_floor + 1'b1;
                    w_step_nxt  = STEP_RELOAD;
                    if (w_floor_nxt == r_target) begin
                        w_state_nxt = ST_DOOR;
                        w_door_nxt  = DOOR_RELOAD;
                    end
                end else begin
                    w_step_nxt = r_step_cnt - 1'b1;
                end
            end
            ST_MOVE_DOWN: begin
                if (r_step_cnt == '0) begin
                    w_floor_nxt = (r_floor == '0) ? r_floor : r_floor - 1'b1;
                    w_step_nxt  = STEP_RELOAD;
                    if (w_floor_nxt == r_target) begin
                        w_state_nxt = ST_DOOR;
                        w_door_nxt  = DOOR_RELOAD;
                    end
                end else begin
                    w_step_nxt = r_step_cnt - 1'b1;
                end
            end
            default: begin
                if (r_door_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_door_nxt = r_door_cnt - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_floor    <= HOME;
            r_target   <= HOME;
            r_step_cnt <= '0;
            r_door_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_floor    <= w_floor_nxt;
            r_target   <= w_target_nxt;
            r_step_cnt <= w_step_nxt;
            r_door_cnt <= w_door_nxt;
        end
    end

    // Arrival is flagged on the edge that enters DOOR so the scheduler clears on that same edge.
    assign o_arrive       = (w_state_nxt == ST_DOOR) && (r_state != ST_DOOR);
    assign o_arrive_floor = w_target_nxt;

    assign o_idle  = (r_state == ST_IDLE);
    assign o_floor = r_floor;
    assign o_im    = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign o_up    = (r_state == ST_MOVE_UP);
    assign o_door  = (r_state == ST_DOOR);

endmodule

// File: rtl/lift_scheduler.sv
// Two-car lift scheduler: hall request capture, pending/assigned tracking
// and nearest-idle-car dispatch driving two lift_car instances.
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int     MOVE_CYCLES = 2,
    parameter int     DOOR_CYCLES = 4,
    parameter floor_t LIFT1_HOME  = 3'd0,
    parameter floor_t LIFT2_HOME  = 3'd4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req_valid,
    input  floor_t       i_req_floor,
    output logic         o_req_ready,
    output logic [7:0]   o_pending,
    output logic         o_assign_valid,
    output logic [1:0]   o_assign_lift,
    output floor_t       o_lift1_floor,
    output floor_t       o_lift2_floor,
    output logic         o_lift1_im,
    output logic         o_lift2_im,
    output logic         o_lift1_up,
    output logic         o_lift2_up,
    output logic         o_lift1_door,
    output logic         o_lift2_door
);

    logic [7:0] r_pending;
    logic [7:0] r_assigned;
    logic       r_assign_valid;
    assign_t    r_assign_lift;

    logic       w_idle1, w_idle2;
    logic       w_arrive1, w_arrive2;
    floor_t     w_arrive_floor1, w_arrive_floor2;
    logic       w_start1, w_start2;

    logic [7:0] w_avail;
    logic       w_any;
    floor_t     w_sel_floor;
    floor_t     w_dist1, w_dist2;
    logic       w_dispatch;
    logic       w_pick2;
    logic       w_door_hit;
    logic [7:0] w_set_mask;
    logic [7:0] w_clear_mask;
    logic [7:0] w_dispatch_mask;

    assign w_avail = r_pending & ~r_assigned;

    always_comb begin
        w_any       = 1'b0;
        w_sel_floor = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_avail[i]) begin
                w_any       = 1'b1;
                w_sel_floor = floor_t'(i);
            end
        end
    end

    assign w_dist1    = floor_dist(o_lift1_floor, w_sel_floor);
    assign w_dist2    = floor_dist(o_lift2_floor, w_sel_floor);
    assign w_dispatch = w_any && (w_idle1 || w_idle2);
    // Lift1 wins ties and is preferred whenever it is the only idle car.
    assign w_pick2    = w_idle2 && (!w_idle1 || (w_dist2 < w_dist1));
    assign w_start1   = w_dispatch && !w_pick2;
    assign w_start2   = w_dispatch && w_pick2;

    assign w_door_hit = (o_lift1_door && (o_lift1_floor == i_req_floor)) ||
                        (o_lift2_door && (o_lift2_floor == i_req_floor));

    assign w_set_mask      = (i_req_valid && !w_door_hit) ? (8'b1 << i_req_floor) : 8'b0;
    assign w_clear_mask    = (w_arrive1 ? (8'b1 << w_arrive_floor1) : 8'b0) |
                             (w_arrive2 ? (8'b1 << w_arrive_floor2) : 8'b0);
    assign w_dispatch_mask = w_dispatch ? (8'b1 << w_sel_floor) : 8'b0;

    // Clears are applied last so an arrival beats a same-edge request or dispatch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending      <= '0;
            r_assigned     <= '0;
            r_assign_valid <= 1'b0;
            r_assign_lift  <= ASSIGN_NONE;
        end else begin
            r_pending      <= (r_pending | w_set_mask) & ~w_clear_mask;
            r_assigned     <= (r_assigned | w_dispatch_mask) & ~w_clear_mask;
            r_assign_valid <= w_dispatch;
            r_assign_lift  <= w_start2 ? ASSIGN_L2 : (w_start1 ? ASSIGN_L1 : ASSIGN_NONE);
        end
    end

    lift_car #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES),
        .HOME        (LIFT1_HOME)
    ) u_car1 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (w_start1),
        .i_target       (w_sel_floor),
        .o_idle         (w_idle1),
        .o_floor        (o_lift1_floor),
        .o_im           (o_lift1_im),
        .o_up           (o_lift1_up),
        .o_door         (o_lift1_door),
        .o_arrive       (w_arrive1),
        .o_arrive_floor (w_arrive_floor1)
    );

    lift_car #(
        .MOVE_CYCLES (MOVE_CYCLES),
        .DOOR_CYCLES (DOOR_CYCLES),
        .HOME        (LIFT2_HOME)
    ) u_car2 (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (w_start2),
        .i_target       (w_sel_floor),
        .o_idle         (w_idle2),
        .o_floor        (o_lift2_floor),
        .o_im           (o_lift2_im),
        .o_up           (o_lift2_up),
        .o_door         (o_lift2_door),
        .o_arrive       (w_arrive2),
        .o_arrive_floor (w_arrive_floor2)
    );

    assign o_req_ready    = ~i_rst;
    assign o_pending      = r_pending;
    assign o_assign_valid = r_assign_valid;
    assign o_assign_lift  = r_assign_lift;

endmodule

// File: tb/tb_lift_scheduler.sv
// Directed bench for lift_scheduler with default parameters (homes 0 and 4).
module tb_lift_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = 3'd0;
    logic       req_ready;
    logic [7:0] pending;
    logic       assign_valid;
    logic [1:0] assign_lift;
    logic [2:0] l1_floor, l2_floor;
    logic       l1_im, l2_im, l1_up, l2_up, l1_door, l2_door;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lift_scheduler dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .i_req_floor    (req_floor),
        .o_req_ready    (req_ready),
        .o_pending      (pending),
        .o_assign_valid (assign_valid),
        .o_assign_lift  (assign_lift),
        .o_lift1_floor  (l1_floor),
        .o_lift2_floor  (l2_floor),
        .o_lift1_im     (l1_im),
        .o_lift2_im     (l2_im),
        .o_lift1_up     (l1_up),
        .o_lift2_up     (l2_up),
        .o_lift1_door   (l1_door),
        .o_lift2_door   (l2_door)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        // Reset state while rst is held
        tick(2);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_l1_floor", 32'(l1_floor), 0);
        chk("rst_l2_floor", 32'(l2_floor), 4);
        chk("rst_motion", 32'({l1_im, l2_im, l1_up, l2_up, l1_door, l2_door}), 0);
        chk("rst_assign", 32'({assign_valid, assign_lift}), 0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 32'(req_ready), 1);

        // Floor 3 goes to lift2 (distance 1 vs 3)
        req_valid = 1'b1; req_floor = 3'd3;
        tick(1);
        chk("f3_pending_set", 32'(pending), 32'h08);
        chk("f3_no_early_dispatch", 32'(assign_valid), 0);
        req_valid = 1'b0;
        tick(1);
        chk("f3_assign_valid", 32'(assign_valid), 1);
        chk("f3_assign_lift", 32'(assign_lift), 32'h2);
        chk("f3_l2_im", 32'(l2_im), 1);
        chk("f3_l2_up", 32'(l2_up), 0);
        chk("f3_l2_floor_start", 32'(l2_floor), 4);
        chk("f3_l1_idle", 32'({l1_im, l1_door}), 0);
        tick(1);
        chk("f3_pulse_one_cycle", 32'(assign_valid), 0);
        chk("f3_l2_floor_mid", 32'(l2_floor), 4);
        // Same-edge request and arrival clear: the clear wins
        req_valid = 1'b1; req_floor = 3'd3;
        tick(1);
        chk("f3_l2_floor_arrive", 32'(l2_floor), 3);
        chk("f3_l2_door", 32'(l2_door), 1);
        chk("f3_l2_im_stop", 32'(l2_im), 0);
        chk("f3_pending_clr", 32'(pending), 32'h00);
        req_valid = 1'b0;
        tick(1);
        chk("f3_no_redispatch", 32'(assign_valid), 0);
        tick(2);
        chk("f3_door_last", 32'(l2_door), 1);
        tick(1);
        chk("f3_door_closed", 32'(l2_door), 0);
        chk("f3_l2_floor_final", 32'(l2_floor), 3);

        // Floor 2: tie at distance 2, lift1 wins
        do_reset();
        req_valid = 1'b1; req_floor = 3'd2;
        tick(1);
        req_valid = 1'b0;
        chk("f2_pending", 32'(pending), 32'h04);
        tick(1);
        chk("f2_assign", 32'({assign_valid, assign_lift}), 32'h5);
        chk("f2_l1_up", 32'({l1_im, l1_up}), 32'h3);
        tick(3);
        chk("f2_l1_floor1", 32'(l1_floor), 1);
        tick(1);
        chk("f2_l1_floor2", 32'(l1_floor), 2);
        chk("f2_l1_door", 32'({l1_door, l1_im, l1_up}), 32'h4);
        chk("f2_pending_clr", 32'(pending), 32'h00);

        // Floors 1, 5, 6 back to back
        do_reset();
        req_valid = 1'b1; req_floor = 3'd1;
        tick(1);
        req_floor = 3'd5;
        tick(1);
        chk("f15_first_assign", 32'({assign_valid, assign_lift}), 32'h5);
        chk("f15_pending", 32'(pending), 32'h22);
        req_floor = 3'd6;
        tick(1);
        chk("f15_second_assign", 32'({assign_valid, assign_lift}), 32'h6);
        chk("f156_pending", 32'(pending), 32'h62);
        req_valid = 1'b0;
        tick(1);
        chk("f6_waits", 32'(assign_valid), 0);
        tick(4);
        chk("f6_still_waiting", 32'({assign_valid, pending}), 32'h040);
        tick(1);
        chk("f6_to_lift1", 32'({assign_valid, assign_lift}), 32'h5);
        chk("f6_l1_moving_up", 32'({l1_im, l1_up, l1_floor}), 32'h19);

        // Floor 0 with lift1 parked there: straight to DOOR, repeat dropped
        do_reset();
        req_valid = 1'b1; req_floor = 3'd0;
        tick(1);
        req_valid = 1'b0;
        chk("f0_pending", 32'(pending), 32'h01);
        tick(1);
        chk("f0_assign", 32'({assign_valid, assign_lift}), 32'h5);
        chk("f0_door_no_im", 32'({l1_door, l1_im}), 32'h2);
        chk("f0_pending_clr", 32'(pending), 32'h00);
        req_valid = 1'b1; req_floor = 3'd0;
        tick(1);
        req_valid = 1'b0;
        chk("f0_repeat_dropped", 32'(pending), 32'h00);
        chk("f0_im_never", 32'(l1_im), 0);
        tick(1);
        chk("f0_no_second_assign", 32'(assign_valid), 0);

        // Duplicate request for a pending floor is merged
        do_reset();
        req_valid = 1'b1; req_floor = 3'd3;
        tick(1);
        tick(1);
        req_valid = 1'b0;
        chk("merge_pending", 32'(pending), 32'h08);
        chk("merge_first_assign", 32'(assign_valid), 1);
        tick(1);
        chk("merge_no_second", 32'(assign_valid), 0);

        // Async reset while lift2 travels toward floor 7
        do_reset();
        req_valid = 1'b1; req_floor = 3'd7;
        tick(1);
        req_valid = 1'b0;
        tick(1);
        chk("f7_assign", 32'({assign_valid, assign_lift}), 32'h6);
        tick(2);
        chk("f7_l2_floor5", 32'(l2_floor), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_l2_floor", 32'(l2_floor), 4);
        chk("arst_l2_state", 32'({l2_im, l2_up, l2_door}), 0);
        chk("arst_pending", 32'(pending), 32'h00);
        chk("arst_ready", 32'(req_ready), 0);
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("arst_no_resume", 32'({assign_valid, l2_im, l2_floor}), 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
